// File: rtl/input_debounce.sv
// Two-flop synchronizer plus stability FSM; emits debounced level and edge pulses.
// Latency: a/rise/fall update STABLE_CYCLES+1 edges after the first edge that captures a raw change.
// No backpressure: enable=0 aborts any pending qualification and freezes the level.
module input_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    output logic a,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               SINGLE   = (STABLE_CYCLES == 1);

    logic             s1;
    logic             s_raw;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             a_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             busy_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s_raw <= 1'b0;
        end else begin
            s1    <= raw;
            s_raw <= s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            LOW: begin
                if (enable && s_raw) begin
                    if (SINGLE) begin
                        next_state = HIGH;
                    end else begin
                        next_state = CHK_HIGH;
                        cnt_nxt    = CNT_ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!enable || !s_raw) begin
                    next_state = LOW;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = HIGH;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (enable && !s_raw) begin
                    if (SINGLE) begin
                        next_state = LOW;
                    end else begin
                        next_state = CHK_LOW;
                        cnt_nxt    = CNT_ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (!enable || s_raw) begin
                    next_state = HIGH;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = LOW;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = LOW;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state change.
    always_comb begin
        a_nxt    = (next_state == HIGH) || (next_state == CHK_LOW);
        busy_nxt = (next_state == CHK_HIGH) || (next_state == CHK_LOW);
        rise_nxt = (next_state == HIGH) && ((state == LOW) || (state == CHK_HIGH));
        fall_nxt = (next_state == LOW) && ((state == HIGH) || (state == CHK_LOW));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            busy <= 1'b0;
        end else begin
            a    <= a_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: N=4 and N=1 instances against a run-length reference model.
module tb_input_debounce;

    localparam int N_A = 4;
    localparam int N_B = 1;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic raw    = 1'b0;
    logic enable = 1'b1;
    logic a4, rise4, fall4, busy4;
    logic a1, rise1, fall1, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    input_debounce #(.STABLE_CYCLES(N_A), .CNT_W(8)) u_n4 (
        .clock(clock), .reset(reset), .raw(raw), .enable(enable),
        .a(a4), .rise(rise4), .fall(fall4), .busy(busy4)
    );

    input_debounce #(.STABLE_CYCLES(N_B), .CNT_W(8)) u_n1 (
        .clock(clock), .reset(reset), .raw(raw), .enable(enable),
        .a(a1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    // Reference: a flips once the enabled synchronized input has differed from it for N samples in a row.
    typedef struct {
        int run;
        bit a;
        bit rise;
        bit fall;
        bit busy;
    } model_t;

    model_t md[2];
    bit     m_s1   = 1'b0;
    bit     m_sraw = 1'b0;

    function automatic model_t step(model_t m, bit s, bit en, int n);
        model_t r;
        r      = m;
        r.rise = 1'b0;
        r.fall = 1'b0;
        if (en && (s != m.a)) r.run = m.run + 1;
        else                  r.run = 0;
        if (r.run == n) begin
            r.a    = !m.a;
            r.run  = 0;
            r.rise = r.a;
            r.fall = !r.a;
        end
        r.busy = (r.run != 0);
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) md[d] <= '{0, 1'b0, 1'b0, 1'b0, 1'b0};
            m_s1   <= 1'b0;
            m_sraw <= 1'b0;
        end else begin
            md[0]  <= step(md[0], m_sraw, enable, N_A);
            md[1]  <= step(md[1], m_sraw, enable, N_B);
            m_sraw <= m_s1;
            m_s1   <= raw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("model_n4", {28'd0, a4, rise4, fall4, busy4},
              {28'd0, md[0].a, md[0].rise, md[0].fall, md[0].busy});
        check("model_n1", {28'd0, a1, rise1, fall1, busy1},
              {28'd0, md[1].a, md[1].rise, md[1].fall, md[1].busy});
    end

    // Expected is {a, rise, fall, busy} of the N=4 instance after the edge following the drive.
    typedef struct {
        logic       raw;
        logic       en;
        logic [3:0] exp;
    } vec_t;

    vec_t tv[42];

    initial begin
        int  e4;
        int  e1;
        bit  seen;
        bit  busy_seen;
        bit  rise_at;
        int  hold;

        tv[0]  = '{1'b1, 1'b1, 4'b0000}; tv[1]  = '{1'b1, 1'b1, 4'b0000};
        tv[2]  = '{1'b1, 1'b1, 4'b0001}; tv[3]  = '{1'b1, 1'b1, 4'b0001};
        tv[4]  = '{1'b1, 1'b1, 4'b0001}; tv[5]  = '{1'b1, 1'b1, 4'b1100};
        tv[6]  = '{1'b1, 1'b1, 4'b1000}; tv[7]  = '{1'b0, 1'b1, 4'b1000};
        tv[8]  = '{1'b0, 1'b1, 4'b1000}; tv[9]  = '{1'b0, 1'b1, 4'b1001};
        tv[10] = '{1'b0, 1'b1, 4'b1001}; tv[11] = '{1'b0, 1'b1, 4'b1001};
        tv[12] = '{1'b0, 1'b1, 4'b0010}; tv[13] = '{1'b0, 1'b1, 4'b0000};
        tv[14] = '{1'b1, 1'b1, 4'b0000}; tv[15] = '{1'b1, 1'b1, 4'b0000};
        tv[16] = '{1'b1, 1'b1, 4'b0001}; tv[17] = '{1'b0, 1'b1, 4'b0001};
        tv[18] = '{1'b0, 1'b1, 4'b0001}; tv[19] = '{1'b0, 1'b1, 4'b0000};
        tv[20] = '{1'b0, 1'b1, 4'b0000}; tv[21] = '{1'b1, 1'b1, 4'b0000};
        tv[22] = '{1'b1, 1'b1, 4'b0000}; tv[23] = '{1'b1, 1'b1, 4'b0001};
        tv[24] = '{1'b1, 1'b1, 4'b0001}; tv[25] = '{1'b1, 1'b0, 4'b0000};
        tv[26] = '{1'b1, 1'b0, 4'b0000}; tv[27] = '{1'b1, 1'b1, 4'b0001};
        tv[28] = '{1'b1, 1'b1, 4'b0001}; tv[29] = '{1'b1, 1'b1, 4'b0001};
        tv[30] = '{1'b1, 1'b1, 4'b1100}; tv[31] = '{1'b1, 1'b1, 4'b1000};
        tv[32] = '{1'b0, 1'b1, 4'b1000}; tv[33] = '{1'b0, 1'b1, 4'b1000};
        tv[34] = '{1'b0, 1'b1, 4'b1001}; tv[35] = '{1'b0, 1'b0, 4'b1000};
        tv[36] = '{1'b0, 1'b0, 4'b1000}; tv[37] = '{1'b0, 1'b1, 4'b1001};
        tv[38] = '{1'b0, 1'b1, 4'b1001}; tv[39] = '{1'b0, 1'b1, 4'b1001};
        tv[40] = '{1'b0, 1'b1, 4'b0010}; tv[41] = '{1'b0, 1'b1, 4'b0000};

        // Reset held with raw high, then count edges to the first rise.
        #1 reset = 1'b0;
        raw    = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("reset_n4", {28'd0, a4, rise4, fall4, busy4}, 32'd0);
        check("reset_n1", {28'd0, a1, rise1, fall1, busy1}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        e4 = 0;
        e1 = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clock);
            #1;
            if (rise4 && e4 == 0) e4 = e;
            if (rise1 && e1 == 0) e1 = e;
        end
        check("rst_rise_edge_n4", e4, 6);
        check("rst_rise_edge_n1", e1, 3);
        check("rst_level_n4", {31'd0, a4}, 32'd1);

        @(negedge clock);
        raw = 1'b0;
        repeat (12) @(negedge clock);

        for (int i = 0; i < 42; i++) begin
            raw    = tv[i].raw;
            enable = tv[i].en;
            @(negedge clock);
            check($sformatf("vec%0d", i), {28'd0, a4, rise4, fall4, busy4}, {28'd0, tv[i].exp});
        end

        // Asynchronous reset while qualifying a fall.
        raw = 1'b1;
        repeat (8) @(negedge clock);
        raw = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_chk_low", {30'd0, a4, busy4}, 32'd3);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_reset_n4", {28'd0, a4, rise4, fall4, busy4}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clock);
            #1;
            if (fall4 || rise4) seen = 1'b1;
        end
        check("no_pulse_after_reset", {31'd0, seen}, 32'd0);

        // N=1 step: a and rise two edges after the capturing edge, busy never set.
        @(negedge clock);
        raw       = 1'b1;
        e1        = 0;
        busy_seen = 1'b0;
        rise_at   = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock);
            #1;
            if (busy1) busy_seen = 1'b1;
            if (a1 && e1 == 0) begin
                e1      = e;
                rise_at = rise1;
            end
        end
        check("n1_level_edge", e1, 3);
        check("n1_rise_with_level", {31'd0, rise_at}, 32'd1);
        check("n1_busy_never", {31'd0, busy_seen}, 32'd0);

        // Random run lengths and enable drops, checked by the model monitor.
        @(negedge clock);
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                raw  = !raw;
                hold = $urandom_range(1, 7);
            end
            hold--;
            enable = ($urandom_range(0, 9) != 0);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
